// File: rtl/ctr_pkg.sv
// Shared constants and helpers for the up/down counter family.
// clog2_f lets instantiators size WIDTH from a desired MODULUS.
package ctr_pkg;

  localparam int SAT_WRAP = 0;
  localparam int SAT_HOLD = 1;

  // Bits needed to hold values 0..value-1 (value >= 2).
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_updown_ctr_if.sv
// Control/status bundle for mod_updown_ctr: the master drives the controls,
// the slave (the counter) returns the count and flags.
interface mod_updown_ctr_if #(
  parameter int WIDTH = 4
) ();

  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;

  modport master (output en, up_dn, load, d, input q, tc, ovf);
  modport slave  (input en, up_dn, load, d, output q, tc, ovf);

endinterface

// File: rtl/mod_updown_ctr_jk_cell.sv
// Single JK flip-flop with synchronous active-high reset; one per counter bit.
module mod_updown_ctr_jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case ({j_i, k_i})
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      2'b11:   q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/mod_updown_ctr.sv
// Parametrised synchronous up/down counter built from JK cells, with load,
// wrap/saturate at range ends, combinational terminal count and registered overflow.
module mod_updown_ctr
  import ctr_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 2 ** WIDTH,
  parameter int SATURATE = SAT_WRAP
) (
  input logic             clk,
  input logic             rst,
  mod_updown_ctr_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
  localparam bit               HOLD  = (SATURATE == SAT_HOLD);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] t_up;
  logic [WIDTH-1:0] t_dn;
  logic [WIDTH-1:0] tog;
  logic [WIDTH-1:0] v;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             force_v;
  logic             at_max;
  logic             at_min;
  logic             tc_raw;
  logic             ovf_d;
  logic             ovf_q;

  assign at_max = (cnt_q == MAX_V);
  assign at_min = (cnt_q == '0);

  // Toggle masks for a plain binary step; each cell also gets J/K from the mux below.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    if (gi == 0) begin : g_lsb
      assign t_up[gi] = 1'b1;
      assign t_dn[gi] = 1'b1;
    end else begin : g_upper
      assign t_up[gi] = &cnt_q[gi-1:0];
      assign t_dn[gi] = &(~cnt_q[gi-1:0]);
    end

    mod_updown_ctr_jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j_i (j[gi]),
      .k_i (k[gi]),
      .q_o (cnt_q[gi])
    );
  end

  // Load and range-end cases force a value; ordinary steps toggle.
  always_comb begin
    force_v = 1'b0;
    v       = cnt_q;
    tog     = '0;
    if (bus.load) begin
      force_v = 1'b1;
      v       = (bus.d > MAX_V) ? MAX_V : bus.d;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (at_max) begin
          force_v = 1'b1;
          v       = HOLD ? cnt_q : '0;
        end else begin
          tog = t_up;
        end
      end else begin
        if (at_min) begin
          force_v = 1'b1;
          v       = HOLD ? cnt_q : MAX_V;
        end else begin
          tog = t_dn;
        end
      end
    end
  end

  assign j = force_v ? v  : tog;
  assign k = force_v ? ~v : tog;

  assign tc_raw = ~rst & bus.en & ~bus.load &
                  ((bus.up_dn & at_max) | (~bus.up_dn & at_min));
  assign ovf_d  = tc_raw;

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign bus.q   = cnt_q;
  assign bus.tc  = tc_raw;
  assign bus.ovf = ovf_q;

endmodule
